// File: rtl/project_types.sv
// Shared pipeline types used by the stage-boundary register blocks.
package project_types;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/pipe_skid_stage.sv
// Two-entry skid-buffered pipeline boundary register with registered in_ready,
// synchronous flush and asynchronous active-low reset.
module pipe_skid_stage
  import project_types::*;
#(
  parameter int WIDTH      = 32,
  parameter bit FLUSH_ZERO = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  skid_state_t      state, state_n;
  logic             ready_q;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             in_fire, out_fire;
  logic             load_main_in, load_main_skid, load_skid;

  assign in_fire  = in_valid & ready_q;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_n        = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state)
      SKID_EMPTY: begin
        if (in_fire) begin
          load_main_in = 1'b1;
          state_n      = SKID_ONE;
        end
      end
      SKID_ONE: begin
        if (in_fire && out_fire) begin
          load_main_in = 1'b1;
        end else if (in_fire) begin
          load_skid = 1'b1;
          state_n   = SKID_FULL;
        end else if (out_fire) begin
          state_n = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (out_fire) begin
          load_main_skid = 1'b1;
          state_n        = SKID_ONE;
        end
      end
      default: state_n = SKID_EMPTY;
    endcase
    // Flush overrides every transition and discards any same-cycle accept.
    if (flush) begin
      state_n        = SKID_EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  // in_ready comes from its own flop, precomputed from next state, so it never
  // sees out_ready or flush combinationally; it stays low until the first edge after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= SKID_EMPTY;
      ready_q <= 1'b0;
    end else begin
      state   <= state_n;
      ready_q <= (state_n != SKID_FULL);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      if (FLUSH_ZERO) begin
        main_q <= '0;
        skid_q <= '0;
      end
    end else begin
      if (load_main_in) begin
        main_q <= in_data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = (state != SKID_EMPTY);
  assign out_data  = main_q;
  assign occupancy = state;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage: directed scenarios plus a seeded random run.
module tb_pipe_skid_stage;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [WIDTH-1:0] sb_q[$];
  logic             m_ready = 1'b0;
  logic             m_zero  = 1'b1;

  pipe_skid_stage #(.WIDTH(WIDTH), .FLUSH_ZERO(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: compares DUT outputs against the reference queue mid-cycle, then
  // advances the reference model for the coming rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("rst_out_valid", WIDTH'(out_valid), '0);
      check("rst_in_ready", WIDTH'(in_ready), '0);
      check("rst_occupancy", WIDTH'(occupancy), '0);
      check("rst_out_data", out_data, '0);
      sb_q.delete();
      m_ready = 1'b0;
      m_zero  = 1'b1;
    end else begin
      check("in_ready", WIDTH'(in_ready), WIDTH'(m_ready));
      check("occupancy", WIDTH'(occupancy), WIDTH'(sb_q.size()));
      check("out_valid", WIDTH'(out_valid), WIDTH'(sb_q.size() != 0));
      if (sb_q.size() != 0) check("out_data", out_data, sb_q[0]);
      else if (m_zero) check("out_data_zero", out_data, '0);
      if (flush) begin
        sb_q.delete();
        m_zero = 1'b1;
      end else begin
        if (sb_q.size() != 0 && out_ready) void'(sb_q.pop_front());
        if (in_valid && m_ready) begin
          sb_q.push_back(in_data);
          m_zero = 1'b0;
        end
      end
      m_ready = (sb_q.size() < 2);
    end
  end

  task automatic cyc(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    cyc(1'b0, '0, 1'b1, 1'b0);
    check("ready_after_release", WIDTH'(in_ready), 1);

    // Streaming at full rate.
    for (int i = 1; i <= 8; i++) cyc(1'b1, WIDTH'(i), 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    check("stream_drained", WIDTH'(occupancy), 0);

    // Backpressure: third word must wait until space frees up.
    cyc(1'b1, 32'hA, 1'b0, 1'b0);
    cyc(1'b1, 32'hB, 1'b0, 1'b0);
    cyc(1'b1, 32'hC, 1'b0, 1'b0);
    check("bp_full_occ", WIDTH'(occupancy), 2);
    check("bp_full_ready", WIDTH'(in_ready), 0);
    check("bp_hold_data", out_data, 32'hA);
    cyc(1'b1, 32'hC, 1'b1, 1'b0);
    check("bp_next_b", out_data, 32'hB);
    cyc(1'b1, 32'hC, 1'b1, 1'b0);
    check("bp_next_c", out_data, 32'hC);
    cyc(1'b0, '0, 1'b1, 1'b0);
    check("bp_drained", WIDTH'(occupancy), 0);

    // Flush from full with a competing input.
    cyc(1'b1, 32'h11, 1'b0, 1'b0);
    cyc(1'b1, 32'h22, 1'b0, 1'b0);
    cyc(1'b1, 32'h33, 1'b0, 1'b1);
    check("flush_valid", WIDTH'(out_valid), 0);
    check("flush_occ", WIDTH'(occupancy), 0);
    check("flush_data", out_data, 0);
    cyc(1'b0, '0, 1'b1, 1'b0);

    // Flush from one entry while it is consumed and a new word is offered.
    cyc(1'b1, 32'h44, 1'b0, 1'b0);
    cyc(1'b1, 32'h55, 1'b1, 1'b1);
    check("flush_fire_occ", WIDTH'(occupancy), 0);
    cyc(1'b0, '0, 1'b1, 1'b0);

    // Simultaneous accept and consume in SKID_ONE.
    cyc(1'b1, 32'h5, 1'b0, 1'b0);
    cyc(1'b1, 32'h6, 1'b1, 1'b0);
    check("simul_data", out_data, 32'h6);
    check("simul_occ", WIDTH'(occupancy), 1);
    cyc(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset with two entries held.
    cyc(1'b1, 32'h71, 1'b0, 1'b0);
    cyc(1'b1, 32'h72, 1'b0, 1'b0);
    #3 rst = 1'b0;
    #1;
    check("arst_valid", WIDTH'(out_valid), 0);
    check("arst_occ", WIDTH'(occupancy), 0);
    check("arst_data", out_data, 0);
    check("arst_ready", WIDTH'(in_ready), 0);
    @(posedge clk);
    #1;
    cyc(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    cyc(1'b0, '0, 1'b1, 1'b0);
    check("arst_release_ready", WIDTH'(in_ready), 1);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 1)), WIDTH'($urandom), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 31) == 0));
    end
    repeat (4) cyc(1'b0, '0, 1'b1, 1'b0);
    check("final_empty", WIDTH'(occupancy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
